// File: rtl/serial_frame_decoder.sv
// Assembles big-endian serial command frames from the RS232 byte stream.
// UPLOAD payloads become external-memory writes. Other commands are reported through cmd_done.
module serial_frame_decoder #(
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        rx_error,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        pause_req,
  output logic        cmd_done,
  output logic [7:0]  cmd_code,
  output logic [31:0] cmd_arg,
  output logic [31:0] cmd_words,
  output logic        busy,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {S_LEN, S_CMD, S_PAY} state_t;

  localparam logic [7:0] CMD_UPLOAD = 8'd2;
  localparam logic [7:0] CMD_LAST   = 8'd3;

  state_t      state_q, state_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] sr_q, sr_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        pause_q, pause_d;
  logic        done_q, done_d;
  logic [7:0]  code_q, code_d;
  logic [31:0] arg_q, arg_d;
  logic [31:0] words_q, words_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;

  logic [31:0] word;
  logic        abort;
  logic [1:0]  abort_code;
  logic        busy_w;

  // Only three bytes need storing: the fourth arrives on rx_byte in the completing cycle.
  assign word   = {sr_q, rx_byte};
  assign busy_w = (state_q != S_LEN) || (byte_idx_q != 2'd0);

  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    sr_d        = sr_q;
    idx_d       = idx_q;
    wr_addr_d   = wr_addr_q;
    tmo_cnt_d   = busy_w ? tmo_cnt_q + 32'd1 : '0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pause_d     = pause_q;
    done_d      = 1'b0;
    code_d      = code_q;
    arg_d       = arg_q;
    words_d     = words_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    abort       = 1'b0;
    abort_code  = 2'd0;

    if (rx_error) begin
      abort      = 1'b1;
      abort_code = 2'd3;
    end else if (rx_valid) begin
      tmo_cnt_d  = '0;
      sr_d       = {sr_q[15:0], rx_byte};
      byte_idx_d = byte_idx_q + 2'd1;
      if (!busy_w) err_code_d = 2'd0;
      if (byte_idx_q == 2'd3) begin
        unique case (state_q)
          S_LEN: begin
            words_d = word;
            if (word > MAX_WORDS) begin
              abort      = 1'b1;
              abort_code = 2'd1;
            end else begin
              state_d = S_CMD;
            end
          end
          S_CMD: begin
            code_d = word[7:0];
            if ((word[31:8] != 24'd0) || (word[7:0] > CMD_LAST) ||
                ((word[7:0] == CMD_UPLOAD) && (words_q == 32'd0))) begin
              abort      = 1'b1;
              abort_code = 2'd1;
            end else if (words_q == 32'd0) begin
              done_d  = 1'b1;
              arg_d   = '0;
              state_d = S_LEN;
            end else begin
              idx_d   = '0;
              pause_d = (word[7:0] == CMD_UPLOAD);
              state_d = S_PAY;
            end
          end
          S_PAY: begin
            if (idx_q == 32'd0) begin
              arg_d     = word;
              wr_addr_d = word;
            end else if (code_q == CMD_UPLOAD) begin
              mem_we_d    = 1'b1;
              mem_addr_d  = wr_addr_q;
              mem_wdata_d = word;
              wr_addr_d   = wr_addr_q + 32'd4;
            end
            idx_d = idx_q + 32'd1;
            if (idx_q == words_q - 32'd1) begin
              done_d  = 1'b1;
              pause_d = 1'b0;
              state_d = S_LEN;
            end
          end
          default: state_d = S_LEN;
        endcase
      end
    end else if (busy_w && (tmo_cnt_q == TIMEOUT_CYCLES - 32'd1)) begin
      abort      = 1'b1;
      abort_code = 2'd2;
    end

    if (abort) begin
      err_d      = 1'b1;
      err_code_d = abort_code;
      pause_d    = 1'b0;
      mem_we_d   = 1'b0;
      done_d     = 1'b0;
      byte_idx_d = '0;
      tmo_cnt_d  = '0;
      state_d    = S_LEN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_LEN;
      byte_idx_q  <= '0;
      sr_q        <= '0;
      idx_q       <= '0;
      wr_addr_q   <= '0;
      tmo_cnt_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pause_q     <= 1'b0;
      done_q      <= 1'b0;
      code_q      <= '0;
      arg_q       <= '0;
      words_q     <= '0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      sr_q        <= sr_d;
      idx_q       <= idx_d;
      wr_addr_q   <= wr_addr_d;
      tmo_cnt_q   <= tmo_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      pause_q     <= pause_d;
      done_q      <= done_d;
      code_q      <= code_d;
      arg_q       <= arg_d;
      words_q     <= words_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pause_req = pause_q;
  assign cmd_done  = done_q;
  assign cmd_code  = code_q;
  assign cmd_arg   = arg_q;
  assign cmd_words = words_q;
  assign busy      = busy_w;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_serial_frame_decoder.sv
// Bench for serial_frame_decoder: a byte-queue frame model is compared every cycle.
// Directed frames also carry hand-computed literal expectations.
module tb_serial_frame_decoder;

  localparam int unsigned TMO  = 40;
  localparam int unsigned MAXW = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        rx_valid = 1'b0;
  logic        rx_error = 1'b0;
  logic        mem_we, pause_req, cmd_done, busy, err;
  logic [31:0] mem_addr, mem_wdata, cmd_arg, cmd_words;
  logic [7:0]  cmd_code;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  serial_frame_decoder #(.MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_error(rx_error),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .pause_req(pause_req),
    .cmd_done(cmd_done), .cmd_code(cmd_code), .cmd_arg(cmd_arg), .cmd_words(cmd_words),
    .busy(busy), .err(err), .err_code(err_code)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT at the rising edge.
  logic [7:0] s_byte;
  logic       s_valid, s_error;
  always @(posedge clk) begin
    s_byte  <= rx_byte;
    s_valid <= rx_valid;
    s_error <= rx_error;
  end

  // Model: frame bytes are queued; word n of the frame is bytes 4n..4n+3.
  logic [7:0]  fb[$];
  int unsigned idle_cnt;
  logic        e_we, e_pause, e_done, e_err;
  logic [31:0] e_addr, e_wdata, e_arg, e_words, m_next_addr;
  logic [7:0]  e_code;
  logic [1:0]  e_errc;

  function automatic logic [31:0] word_at(input int unsigned n);
    return {fb[4*n], fb[4*n+1], fb[4*n+2], fb[4*n+3]};
  endfunction

  task automatic m_reset();
    fb.delete();
    idle_cnt = 0;
    e_we = 0; e_pause = 0; e_done = 0; e_err = 0;
    e_addr = 0; e_wdata = 0; e_arg = 0; e_words = 0; m_next_addr = 0;
    e_code = 0; e_errc = 0;
  endtask

  task automatic m_abort(input logic [1:0] c);
    e_err = 1; e_errc = c; e_pause = 0; e_we = 0; e_done = 0;
    fb.delete();
    idle_cnt = 0;
  endtask

  task automatic m_step();
    logic [31:0] w;
    int unsigned n, p;
    e_we = 0; e_done = 0; e_err = 0;
    if (s_error) m_abort(2'd3);
    else if (s_valid) begin
      idle_cnt = 0;
      if (fb.size() == 0) e_errc = 0;
      fb.push_back(s_byte);
      if (fb.size() % 4 == 0) begin
        n = fb.size() / 4 - 1;
        w = word_at(n);
        if (n == 0) begin
          e_words = w;
          if (w > MAXW) m_abort(2'd1);
        end else if (n == 1) begin
          e_code = w[7:0];
          if (w[31:8] != 0 || w[7:0] > 8'd3 || (w[7:0] == 8'd2 && e_words == 0)) m_abort(2'd1);
          else if (e_words == 0) begin
            e_done = 1; e_arg = 0; fb.delete();
          end else e_pause = (w[7:0] == 8'd2);
        end else begin
          p = n - 2;
          if (p == 0) begin
            e_arg = w; m_next_addr = w;
          end else if (e_code == 8'd2) begin
            e_we = 1; e_addr = m_next_addr; e_wdata = w; m_next_addr = m_next_addr + 4;
          end
          if (p == e_words - 1) begin
            e_done = 1; e_pause = 0; fb.delete();
          end
        end
      end
    end else if (fb.size() != 0) begin
      idle_cnt++;
      if (idle_cnt == TMO) m_abort(2'd2);
    end
  endtask

  // Observations collected from the DUT for the literal checks.
  logic [31:0] wr_a[$], wr_d[$];
  int unsigned n_done, n_err;
  logic        saw_pause;

  always @(negedge clk) begin
    if (!rst) m_reset();
    else m_step();
    chk("busy", busy, fb.size() != 0);
    chk("pause_req", pause_req, e_pause);
    chk("mem_we", mem_we, e_we);
    if (e_we) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
    end
    chk("cmd_done", cmd_done, e_done);
    chk("err", err, e_err);
    chk("err_code", err_code, e_errc);
    chk("cmd_code", cmd_code, e_code);
    chk("cmd_arg", cmd_arg, e_arg);
    chk("cmd_words", cmd_words, e_words);
    if (mem_we) begin
      wr_a.push_back(mem_addr);
      wr_d.push_back(mem_wdata);
    end
    if (cmd_done) n_done++;
    if (err) n_err++;
    if (pause_req) saw_pause = 1;
  end

  task automatic clear_obs();
    wr_a.delete(); wr_d.delete();
    n_done = 0; n_err = 0; saw_pause = 0;
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    rx_byte = b; rx_valid = 1; rx_error = 0;
  endtask

  task automatic put_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) put(w[8*i +: 8]);
  endtask

  task automatic idle(input int unsigned n);
    @(negedge clk);
    rx_valid = 0; rx_error = 0;
    if (n > 1) repeat (n - 1) @(negedge clk);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    clear_obs();
    repeat (3) @(negedge clk);
    #2 rst = 1;
    settle();
    chk("rst_busy", busy, 0);
    chk("rst_words", cmd_words, 0);

    // T1: upload two words at 0x100
    clear_obs();
    put_word(3); put_word(2); put_word(32'h100); put_word(32'hDEADBEEF); put_word(32'h12345678);
    idle(3); settle();
    chk("t1_nwr", wr_a.size(), 2);
    chk("t1_a0", wr_a[0], 32'h100);
    chk("t1_d0", wr_d[0], 32'hDEADBEEF);
    chk("t1_a1", wr_a[1], 32'h104);
    chk("t1_d1", wr_d[1], 32'h12345678);
    chk("t1_pause", saw_pause, 1);
    chk("t1_done", n_done, 1);
    chk("t1_code", cmd_code, 8'd2);
    chk("t1_model_code", e_code, 8'd2);
    chk("t1_arg", cmd_arg, 32'h100);

    // T2: INFO with no payload
    clear_obs();
    put_word(0); put_word(1); idle(3); settle();
    chk("t2_done", n_done, 1);
    chk("t2_code", cmd_code, 8'd1);
    chk("t2_arg", cmd_arg, 0);
    chk("t2_words", cmd_words, 0);
    chk("t2_nwr", wr_a.size(), 0);
    chk("t2_pause", saw_pause, 0);

    // T3: bad commands / lengths, then recovery
    clear_obs();
    put_word(1); put_word(7); idle(2); settle();
    chk("t3_err", n_err, 1);
    chk("t3_code", err_code, 2'd1);
    chk("t3_busy", busy, 0);
    put_word(1); put_word(32'h102); idle(2); settle();
    chk("t3_hi_err", n_err, 2);
    put_word(MAXW + 1); idle(2); settle();
    chk("t3_len_err", n_err, 3);
    chk("t3_len_words", cmd_words, MAXW + 1);
    put_word(0); put_word(2); idle(2); settle();
    chk("t3_up0_err", n_err, 4);
    put_word(0); put_word(0); idle(2); settle();
    chk("t3_nop_done", n_done, 1);
    chk("t3_errc_clr", err_code, 2'd0);
    chk("t3_model_errc", e_errc, 2'd0);

    // T4: timeout inside an upload payload
    clear_obs();
    put_word(2); put_word(2); put_word(32'hFFFFFFFC); idle(TMO + 5); settle();
    chk("t4_err", n_err, 1);
    chk("t4_code", err_code, 2'd2);
    chk("t4_pause_now", pause_req, 0);
    chk("t4_pause_seen", saw_pause, 1);
    chk("t4_nwr", wr_a.size(), 0);

    // A byte arriving exactly on the timeout cycle keeps the frame alive
    clear_obs();
    put_word(1); put_word(1); put(8'h00); idle(TMO - 1);
    put(8'h00); put(8'h00); put(8'h07); idle(2); settle();
    chk("tb_err", n_err, 0);
    chk("tb_done", n_done, 1);
    chk("tb_arg", cmd_arg, 32'h7);

    // T5: address wrap
    clear_obs();
    put_word(3); put_word(2); put_word(32'hFFFFFFFC); put_word(32'h11111111); put_word(32'h22222222);
    idle(2); settle();
    chk("t5_nwr", wr_a.size(), 2);
    chk("t5_a0", wr_a[0], 32'hFFFFFFFC);
    chk("t5_a1", wr_a[1], 32'h0);
    chk("t5_d1", wr_d[1], 32'h22222222);

    // T6: rx_error mid-payload (byte present in the same cycle is ignored)
    clear_obs();
    put_word(4); put_word(2); put_word(32'h200); put_word(32'hAAAA0001); put(8'h55); put(8'h66);
    @(negedge clk);
    rx_byte = 8'h77; rx_valid = 1; rx_error = 1;
    idle(2); settle();
    chk("t6_err", n_err, 1);
    chk("t6_code", err_code, 2'd3);
    chk("t6_nwr", wr_a.size(), 1);
    chk("t6_a0", wr_a[0], 32'h200);
    chk("t6_pause", pause_req, 0);
    put_word(0); put_word(0); idle(2); settle();
    chk("t6_clr", err_code, 2'd0);
    @(negedge clk);
    rx_error = 1;
    idle(2); settle();
    chk("t6_idle_err", n_err, 2);
    chk("t6_idle_code", err_code, 2'd3);

    // Asynchronous reset mid-frame drops it silently
    clear_obs();
    put_word(3); put_word(2); put(8'h01); put(8'h02);
    @(negedge clk);
    rx_valid = 0;
    #2 rst = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_err", n_err, 0);
    chk("rst_busy2", busy, 0);
    chk("rst_words2", cmd_words, 0);
    chk("rst_code2", cmd_code, 0);
    chk("rst_pause2", pause_req, 0);
    #1 rst = 1;
    put_word(0); put_word(1); idle(2); settle();
    chk("rst_recover", n_done, 1);

    // Largest accepted length with a non-upload command
    clear_obs();
    put_word(MAXW); put_word(3); put_word(32'hCAFEF00D);
    for (int i = 1; i < int'(MAXW); i++) put_word(i);
    idle(2); settle();
    chk("max_done", n_done, 1);
    chk("max_err", n_err, 0);
    chk("max_arg", cmd_arg, 32'hCAFEF00D);
    chk("max_words", cmd_words, MAXW);
    chk("max_nwr", wr_a.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
